seq: RTL

SEQ -- requirements
Module: seq

---
 rtl/seq.sv | 78 +++++++
 1 files changed

// File: rtl/seq.sv
// Instruction sequencer: fetches one byte per instruction, then decodes it, then executes it or halts.
// Keeps the PC and the retired-instruction count, and drives the fetch request and phase strobes.
module seq #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] HALT_OP  = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  instr,
    output logic [3:0]  opcode,
    output logic [3:0]  operand,
    output logic        fetch,
    output logic        exec,
    input  logic        exec_done,
    input  logic        branch,
    input  logic [7:0]  branch_tgt,
    input  logic        resume,
    output logic        halted,
    output logic [15:0] instret
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]  r_state;
    logic [7:0]  r_pc;
    logic [7:0]  r_instr;
    logic [15:0] r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_instret <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ack) begin
                        r_instr <= mem_rdata;
                        r_pc    <= r_pc + 8'd1;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: r_state <= (r_instr[7:4] == HALT_OP) ? S_HALT : S_EXEC;
                S_EXEC: begin
                    // Branch inputs only matter on the retiring cycle.
                    if (exec_done) begin
                        r_instret <= r_instret + 16'd1;
                        if (branch) r_pc <= branch_tgt;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: if (resume) r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req  = (r_state == S_FETCH);
    assign fetch    = (r_state == S_DECODE);
    assign exec     = (r_state == S_EXEC);
    assign halted   = (r_state == S_HALT);
    assign mem_addr = r_pc;
    assign instr    = r_instr;
    assign opcode   = r_instr[7:4];
    assign operand  = r_instr[3:0];
    assign instret  = r_instret;

endmodule
